// File: rtl/regfile_op_sequencer.sv
// Command sequencer for the register file: accepts one ALU command per handshake,
// reads both operands through the register file's read ports, computes the result
// and writes it back, returning the result on a one-cycle response pulse.
module regfile_op_sequencer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry,
  output logic              rsp_zero
);

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpAnd  = 3'b010;
  localparam logic [2:0] OpOr   = 3'b011;
  localparam logic [2:0] OpXor  = 3'b100;
  localparam logic [2:0] OpLdi  = 3'b101;
  localparam logic [2:0] OpAddi = 3'b110;
  localparam logic [2:0] OpRd   = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StExec,
    StWrite
  } state_e;

  state_e            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] opa_q;
  logic [DATA_W-1:0] opb_q;

  // Bit DATA_W carries the add carry-out, or the subtract borrow.
  logic [DATA_W:0]   res;
  logic              res_carry;
  logic              res_zero;

  // ALU on the captured operands; logical ops and moves force the carry bit to 0.
  always_comb begin
    res = '0;
    case (op_q)
      OpAdd:   res = {1'b0, opa_q} + {1'b0, opb_q};
      OpSub:   res = {1'b0, opa_q} - {1'b0, opb_q};
      OpAnd:   res = {1'b0, opa_q & opb_q};
      OpOr:    res = {1'b0, opa_q | opb_q};
      OpXor:   res = {1'b0, opa_q ^ opb_q};
      OpLdi:   res = {1'b0, imm_q};
      OpAddi:  res = {1'b0, opa_q} + {1'b0, imm_q};
      OpRd:    res = {1'b0, opa_q};
      default: res = '0;
    endcase
    res_carry = res[DATA_W];
    res_zero  = (res[DATA_W-1:0] == '0);
  end

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      cmd_ready <= 1'b0;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
      rf_en     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          // cmd_ready is 0 right after reset, so the first edge only raises it.
          if (cmd_valid && cmd_ready) begin
            op_q      <= cmd_op;
            rd_q      <= cmd_rd;
            imm_q     <= cmd_imm;
            rf_raddr1 <= cmd_rs1;
            rf_raddr2 <= cmd_rs2;
            cmd_ready <= 1'b0;
            state     <= StRead;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        StRead: begin
          // Operands are captured here, so a write to rs1/rs2 later cannot disturb them.
          opa_q <= rf_rdata1;
          opb_q <= rf_rdata2;
          state <= StExec;
        end
        StExec: begin
          rf_en     <= (op_q != OpRd);
          rf_waddr  <= rd_q;
          rf_wdata  <= res[DATA_W-1:0];
          rsp_valid <= 1'b1;
          rsp_data  <= res[DATA_W-1:0];
          rsp_carry <= res_carry;
          rsp_zero  <= res_zero;
          state     <= StWrite;
        end
        StWrite: begin
          rf_en     <= 1'b0;
          rf_waddr  <= '0;
          rf_wdata  <= '0;
          rsp_valid <= 1'b0;
          rsp_data  <= '0;
          rsp_carry <= 1'b0;
          rsp_zero  <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: directed scenarios plus random commands, checked
// against an arithmetic model of the ALU and a shadow copy of the register file.
module tb_regfile_op_sequencer;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_rd;
  logic [2:0] cmd_rs1;
  logic [2:0] cmd_rs2;
  logic [7:0] cmd_imm;
  logic [2:0] rf_raddr1;
  logic [2:0] rf_raddr2;
  logic [7:0] rf_rdata1;
  logic [7:0] rf_rdata2;
  logic       rf_en;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;

  logic [7:0] rf_mem  [8];
  logic [7:0] ref_regs[8];
  int         tests;
  int         fails;

  regfile_op_sequencer #(
    .DATA_W(8),
    .ADDR_W(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .cmd_imm   (cmd_imm),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .rf_en     (rf_en),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_zero  (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8x8 register file: combinational reads, write on the rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= '0;
    end else if (rf_en) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected {write, carry, data} from plain integer arithmetic.
  function automatic logic [9:0] model(input int op, input int a, input int b, input int imm);
    int d;
    int c;
    int w;
    w = 1;
    c = 0;
    case (op)
      0: begin d = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
      1: begin d = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
      2: d = a & b;
      3: d = a | b;
      4: d = a ^ b;
      5: d = imm;
      6: begin d = (a + imm) % 256; c = (a + imm > 255) ? 1 : 0; end
      default: begin d = a; w = 0; end
    endcase
    return {w[0], c[0], d[7:0]};
  endfunction

  // Issue one command from a falling edge and follow it through to the falling edge
  // of the first cycle after WRITE. keep leaves cmd_valid high for a back-to-back issue.
  task automatic run_cmd(input int op, input int rd, input int rs1, input int rs2,
                         input int imm, input bit keep);
    logic [9:0] e;
    logic [7:0] ed;
    int         n;
    cmd_op    = op[2:0];
    cmd_rd    = rd[2:0];
    cmd_rs1   = rs1[2:0];
    cmd_rs2   = rs2[2:0];
    cmd_imm   = imm[7:0];
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 20), 1);
    e  = model(op, int'(ref_regs[rs1]), int'(ref_regs[rs2]), imm);
    ed = e[7:0];
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0 && !keep) cmd_valid = 1'b0;
      if (c < 3) check("busy_ready", cmd_ready, 0);
      else       check("ready_again", cmd_ready, 1);
      if (c == 0) begin
        check("raddr1", rf_raddr1, rs1);
        check("raddr2", rf_raddr2, rs2);
      end
      if (c == 2) begin
        check("rsp_valid", rsp_valid, 1);
        check("rsp_data", rsp_data, ed);
        check("rsp_carry", rsp_carry, e[8]);
        check("rsp_zero", rsp_zero, 32'(ed == 8'h00));
        check("rf_en", rf_en, e[9]);
        check("rf_waddr", rf_waddr, rd);
        check("rf_wdata", rf_wdata, ed);
      end else begin
        check("rsp_valid_idle", rsp_valid, 0);
        check("rf_en_idle", rf_en, 0);
        check("rsp_data_idle", rsp_data, 0);
        check("rf_wdata_idle", rf_wdata, 0);
      end
    end
    if (e[9]) ref_regs[rd] = ed;
    for (int i = 0; i < 8; i++) check($sformatf("reg%0d", i), rf_mem[i], ref_regs[i]);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_rd    = '0;
    cmd_rs1   = '0;
    cmd_rs2   = '0;
    cmd_imm   = '0;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rf_en", rf_en, 0);
    check("rst_raddr1", rf_raddr1, 0);
    rst = 1'b0;
    check("rel_ready_low", cmd_ready, 0);
    @(negedge clk);
    check("rel_ready_high", cmd_ready, 1);

    // Loads, add, add with carry
    run_cmd(5, 1, 0, 0, 8'h05, 0);
    run_cmd(5, 2, 0, 0, 8'h03, 0);
    run_cmd(0, 3, 1, 2, 0, 0);
    check("r3_is_08", rf_mem[3], 8'h08);
    run_cmd(5, 4, 0, 0, 8'hFF, 0);
    run_cmd(0, 5, 4, 1, 0, 0);
    check("r5_is_04", rf_mem[5], 8'h04);

    // Subtract with borrow, xor to zero
    run_cmd(1, 6, 2, 1, 0, 0);
    check("r6_is_fe", rf_mem[6], 8'hFE);
    run_cmd(4, 7, 1, 1, 0, 0);

    // rd == rs1, then back-to-back with valid held high
    run_cmd(6, 1, 1, 0, 8'h10, 1);
    run_cmd(0, 0, 1, 1, 0, 0);
    check("r0_is_2a", rf_mem[0], 8'h2A);

    // Read-only command
    run_cmd(7, 3, 3, 0, 0, 0);

    // Idle with valid low: nothing moves
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", cmd_ready, 1);
      check("idle_rf_en", rf_en, 0);
    end

    // Random commands, mixing gaps and back-to-back issues
    for (int k = 0; k < 40; k++) begin
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 255)), (k != 39) && ($urandom_range(0, 1) == 1));
    end

    // Reset during EXEC aborts the command
    cmd_op    = 3'b000;
    cmd_rd    = 3'd2;
    cmd_rs1   = 3'd1;
    cmd_rs2   = 3'd1;
    cmd_valid = 1'b1;
    begin
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("abort_accept_timeout", 32'(n < 20), 1);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", cmd_ready, 0);
    check("abort_rf_en", rf_en, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_raddr1", rf_raddr1, 0);
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_rel_ready_low", cmd_ready, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_ready_after", cmd_ready, 1);
      check("abort_no_rsp", rsp_valid, 0);
      check("abort_no_write", rf_en, 0);
    end
    for (int i = 0; i < 8; i++) check($sformatf("abort_reg%0d", i), rf_mem[i], ref_regs[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
